axi_burst_master: RTL

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_master.sv
// axi_burst_master: one AXI4 INCR burst per command, whole-line read or write.
// Ports: clk/rst, cmd_* request, rsp_* completion, AXI4 master AW/W/B/AR/R.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int BURST_LEN  = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LINE_WIDTH = DATA_WIDTH * BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LINE_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int OFF = $clog2(STRB_WIDTH * BURST_LEN);
  localparam int CW  = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RSP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic bready_q, bready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_error_q, rsp_error_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wline_q, wline_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic aw_hs, w_hs, w_fin;
  logic unused_ids;

  assign unused_ids = ^{bid, rid};

  assign awid    = ID_WIDTH'(AXI_ID);
  assign arid    = ID_WIDTH'(AXI_ID);
  assign awlen   = 8'(BURST_LEN - 1);
  assign arlen   = 8'(BURST_LEN - 1);
  assign awsize  = 3'($clog2(STRB_WIDTH));
  assign arsize  = 3'($clog2(STRB_WIDTH));
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign awlock  = 1'b0;
  assign arlock  = 1'b0;
  assign awcache = 4'b0011;
  assign arcache = 4'b0011;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;
  assign wstrb   = '1;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;

  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign bready    = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rdata_q;
  assign cmd_ready = (state_q == IDLE);
  assign wdata     = wdata_mux;
  assign wlast     = wvalid_q && (beat_q == LAST);

  always_comb begin
    wdata_mux = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (beat_q == CW'(k))
        wdata_mux = wline_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    bready_d    = bready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    rdata_d     = rdata_q;
    aw_hs       = awvalid_q && awready;
    w_hs        = wvalid_q && wready;
    w_fin       = w_hs && (beat_q == LAST);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ~OFF_MASK;
          beat_d      = '0;
          rsp_error_d = 1'b0;
          if (cmd_write) begin
            wline_d   = cmd_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          // Counter saturates at FULL; extra beats are dropped.
          if (beat_q == FULL) begin
            rsp_error_d = 1'b1;
          end else begin
            for (int k = 0; k < BURST_LEN; k++) begin
              if (beat_q == CW'(k))
                rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
            beat_d = beat_q + CW'(1);
          end
          if (rresp != 2'b00)
            rsp_error_d = 1'b1;
          if (rlast) begin
            if (beat_q != LAST)
              rsp_error_d = 1'b1;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
          end
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          if (beat_q == LAST) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_fin)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = (bresp != 2'b00);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wline_q <= wline_d;
    rdata_q <= rdata_d;
  end

endmodule
